tm11_dma: RTL and testbench

- Hardware Unibus NPR data mover for the TM11 tape controller.
- Replaces ARM-driven byte copies. It sits between the ARM-side tape byte streams and the Unibus.
- Consumes the controller's current-memory-address and byte-record-count at go, and returns the updated values at completion.
- Tape-read direction packs bytes into memory words (DATO/DATOB). Tape-write direction fetches words (DATI) and unpacks them to bytes.

---
 rtl/tm11_pkg.sv | 29 ++
 rtl/tm11_dma_if.sv | 24 ++
 rtl/tm11_dma_npr_cycle.sv | 141 ++++++++++++++
 rtl/tm11_dma.sv | 224 ++++++++++++++++++++++
 tb/tb_tm11_dma.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm11_pkg.sv
// Shared definitions for the TM11 NPR data mover: Unibus cycle codes,
// controller and bus-cycle state encodings, and default bus timing.
package tm11_pkg;

   localparam int DESKEW_DEF  = 8;
   localparam int TIMEOUT_DEF = 1000;

   localparam logic [1:0] C_DATI  = 2'b00;
   localparam logic [1:0] C_DATO  = 2'b10;
   localparam logic [1:0] C_DATOB = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FILL,
      ST_EMIT,
      ST_REQ,
      ST_FINISH
   } dma_state_t;

   typedef enum logic [2:0] {
      CY_IDLE,
      CY_GNT,
      CY_SETUP,
      CY_MSYN,
      CY_SSYNLO
   } cyc_state_t;

endpackage

// File: rtl/tm11_dma_if.sv
// Unibus NPR master-side signal bundle (request/grant, address, control,
// data and the MSYN/SSYN handshake).
interface tm11_dma_if;

   logic        npr_req;
   logic        npr_gnt;
   logic [17:0] a_out_h;
   logic [1:0]  c_out_h;
   logic [15:0] d_out_h;
   logic        msyn_out_h;
   logic [15:0] d_in_h;
   logic        ssyn_in_h;

   modport master (
      output npr_req, a_out_h, c_out_h, d_out_h, msyn_out_h,
      input  npr_gnt, d_in_h, ssyn_in_h
   );

   modport slave (
      input  npr_req, a_out_h, c_out_h, d_out_h, msyn_out_h,
      output npr_gnt, d_in_h, ssyn_in_h
   );

endinterface

// File: rtl/tm11_dma_npr_cycle.sv
// unibus_npr_cycle: one NPR bus cycle, GNT -> SETUP -> MSYN -> SSYNLO,
// with a non-existent-memory timeout. cyc_ok / cyc_nxm pulse in the clock
// the bus is released so the caller can update its address in step.
module unibus_npr_cycle
   import tm11_pkg::*;
#(
   parameter int DESKEW  = DESKEW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        abort,
   input  logic        go,
   input  logic [17:0] addr,
   input  logic [1:0]  code,
   input  logic [15:0] wdata,
   tm11_dma_if.master  bus,
   output logic [15:0] rdata,
   output logic        cyc_ok,
   output logic        cyc_nxm
);

   localparam int CW = 16;

   cyc_state_t  state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic        req_reg, req_next;
   logic        msyn_reg, msyn_next;
   logic [17:0] a_reg, a_next;
   logic [1:0]  c_reg, c_next;
   logic [15:0] d_reg, d_next;
   logic [15:0] rdata_reg, rdata_next;

   // Sequencer registers
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= CY_IDLE;
         cnt_reg   <= '0;
         req_reg   <= 1'b0;
         msyn_reg  <= 1'b0;
         a_reg     <= '0;
         c_reg     <= '0;
         d_reg     <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         req_reg   <= req_next;
         msyn_reg  <= msyn_next;
         a_reg     <= a_next;
         c_reg     <= c_next;
         d_reg     <= d_next;
         rdata_reg <= rdata_next;
      end
   end

   // Next-state logic; releasing the bus clears request and all bus drivers
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_next   = req_reg;
      msyn_next  = msyn_reg;
      a_next     = a_reg;
      c_next     = c_reg;
      d_next     = d_reg;
      rdata_next = rdata_reg;
      cyc_ok     = 1'b0;
      cyc_nxm    = 1'b0;
      if (abort) begin
         state_next = CY_IDLE;
         req_next   = 1'b0;
         msyn_next  = 1'b0;
         a_next     = '0;
         c_next     = '0;
         d_next     = '0;
      end else begin
         case (state_reg)
            CY_IDLE: begin
               if (go) begin
                  state_next = CY_GNT;
                  req_next   = 1'b1;
                  a_next     = addr;
                  c_next     = code;
                  d_next     = wdata;
               end
            end
            CY_GNT: begin
               if (bus.npr_gnt) begin
                  state_next = CY_SETUP;
                  cnt_next   = '0;
               end
            end
            CY_SETUP: begin
               if (cnt_reg == CW'(DESKEW - 1)) begin
                  state_next = CY_MSYN;
                  msyn_next  = 1'b1;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            CY_MSYN: begin
               if (bus.ssyn_in_h) begin
                  state_next = CY_SSYNLO;
                  msyn_next  = 1'b0;
                  rdata_next = bus.d_in_h;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  state_next = CY_IDLE;
                  msyn_next  = 1'b0;
                  req_next   = 1'b0;
                  a_next     = '0;
                  c_next     = '0;
                  d_next     = '0;
                  cyc_nxm    = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            CY_SSYNLO: begin
               if (!bus.ssyn_in_h) begin
                  state_next = CY_IDLE;
                  req_next   = 1'b0;
                  a_next     = '0;
                  c_next     = '0;
                  d_next     = '0;
                  cyc_ok     = 1'b1;
               end
            end
            default: state_next = CY_IDLE;
         endcase
      end
   end

   assign bus.npr_req    = req_reg;
   assign bus.msyn_out_h = msyn_reg;
   assign bus.a_out_h    = a_reg;
   assign bus.c_out_h    = c_reg;
   assign bus.d_out_h    = d_reg;
   assign rdata          = rdata_reg;

endmodule

// File: rtl/tm11_dma.sv
// tm11_dma: TM11 Unibus NPR data mover. Packs tape bytes into memory words
// (dir=0) or unpacks memory words into tape bytes (dir=1), tracking the
// controller's address and negative byte count.
// Optional: TM11_DMA_STATS_EN adds a 16-bit count of successful bus cycles.
module tm11_dma
   import tm11_pkg::*;
#(
   parameter int DESKEW  = DESKEW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        init_in_h,
   input  logic        start,
   input  logic        dir,
   input  logic [17:0] cma_in,
   input  logic [15:0] brc_in,
   output logic        busy,
   output logic        done,
   output logic        nxm,
   output logic [17:0] cma_out,
   output logic [15:0] brc_out,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   tm11_dma_if.master  bus,
   output logic [15:0] xfer_count
);

   dma_state_t  state_reg, state_next;
   logic        dir_reg, dir_next;
   logic [17:0] cma_reg, cma_next;
   logic [15:0] brc_reg, brc_next;
   logic        nxm_reg, nxm_next;
   logic [15:0] word_reg, word_next;
   logic        hi_reg, hi_next;
   logic        last_reg, last_next;
   logic [1:0]  code_reg, code_next;
   logic        go_reg, go_next;
   logic [15:0] brc_inc;
   logic [15:0] rdata;
   logic        cyc_ok;
   logic        cyc_nxm;

   assign brc_inc = brc_reg + 16'd1;

   unibus_npr_cycle #(
      .DESKEW  (DESKEW),
      .TIMEOUT (TIMEOUT)
   ) u_cycle (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .abort   (init_in_h),
      .go      (go_reg),
      .addr    (cma_reg),
      .code    (code_reg),
      .wdata   (word_reg),
      .bus     (bus),
      .rdata   (rdata),
      .cyc_ok  (cyc_ok),
      .cyc_nxm (cyc_nxm)
   );

   // Controller registers
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= ST_IDLE;
         dir_reg   <= 1'b0;
         cma_reg   <= '0;
         brc_reg   <= '0;
         nxm_reg   <= 1'b0;
         word_reg  <= '0;
         hi_reg    <= 1'b0;
         last_reg  <= 1'b0;
         code_reg  <= C_DATI;
         go_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         cma_reg   <= cma_next;
         brc_reg   <= brc_next;
         nxm_reg   <= nxm_next;
         word_reg  <= word_next;
         hi_reg    <= hi_next;
         last_reg  <= last_next;
         code_reg  <= code_next;
         go_reg    <= go_next;
      end
   end

   // Transfer control: byte packing/unpacking and bus-cycle issue
   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      cma_next   = cma_reg;
      brc_next   = brc_reg;
      nxm_next   = nxm_reg;
      word_next  = word_reg;
      hi_next    = hi_reg;
      last_next  = last_reg;
      code_next  = code_reg;
      go_next    = 1'b0;
      if (init_in_h) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_next = ST_LOAD;
                  dir_next   = dir;
                  cma_next   = cma_in & 18'h3FFFE;
                  brc_next   = brc_in;
                  nxm_next   = 1'b0;
                  hi_next    = 1'b0;
                  last_next  = 1'b0;
               end
            end
            ST_LOAD: begin
               if (dir_reg) begin
                  state_next = ST_REQ;
                  code_next  = C_DATI;
                  go_next    = 1'b1;
               end else begin
                  state_next = ST_FILL;
               end
            end
            ST_FILL: begin
               if (in_valid) begin
                  brc_next = brc_inc;
                  if (!hi_reg) begin
                     word_next = {8'h00, in_data};
                     if (brc_inc == 16'd0 || in_last) begin
                        state_next = ST_REQ;
                        code_next  = C_DATOB;
                        go_next    = 1'b1;
                        last_next  = in_last;
                     end else begin
                        hi_next = 1'b1;
                     end
                  end else begin
                     word_next  = {in_data, word_reg[7:0]};
                     hi_next    = 1'b0;
                     state_next = ST_REQ;
                     code_next  = C_DATO;
                     go_next    = 1'b1;
                     last_next  = in_last;
                  end
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  brc_next = brc_inc;
                  if (!hi_reg) begin
                     if (brc_inc == 16'd0) begin
                        state_next = ST_FINISH;
                     end else begin
                        hi_next = 1'b1;
                     end
                  end else begin
                     hi_next = 1'b0;
                     if (brc_inc == 16'd0) begin
                        state_next = ST_FINISH;
                     end else begin
                        state_next = ST_REQ;
                        code_next  = C_DATI;
                        go_next    = 1'b1;
                     end
                  end
               end
            end
            ST_REQ: begin
               if (cyc_ok) begin
                  cma_next = cma_reg + 18'd2;
                  if (dir_reg) begin
                     word_next  = rdata;
                     hi_next    = 1'b0;
                     state_next = ST_EMIT;
                  end else if (brc_reg == 16'd0 || last_reg) begin
                     state_next = ST_FINISH;
                  end else begin
                     state_next = ST_FILL;
                  end
               end else if (cyc_nxm) begin
                  nxm_next   = 1'b1;
                  state_next = ST_FINISH;
               end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
   assign done      = (state_reg == ST_FINISH);
   assign nxm       = nxm_reg;
   assign cma_out   = cma_reg;
   assign brc_out   = brc_reg;
   assign in_ready  = (state_reg == ST_FILL) && !init_in_h;
   assign out_valid = (state_reg == ST_EMIT);
   assign out_data  = (state_reg == ST_EMIT) ? (hi_reg ? word_reg[15:8] : word_reg[7:0]) : 8'h00;

`ifdef TM11_DMA_STATS_EN
   logic [15:0] xfer_reg;

   // Successful bus cycles since reset; timeouts and aborts do not count
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         xfer_reg <= '0;
      end else if (cyc_ok && !init_in_h) begin
         xfer_reg <= xfer_reg + 16'd1;
      end
   end

   assign xfer_count = xfer_reg;
`else
   assign xfer_count = 16'd0;
`endif

endmodule

// File: tb/tb_tm11_dma.sv
// Directed bench for tm11_dma: a table of transfers checked against a Unibus
// memory responder, plus init-abort and non-existent-memory sequences.
module tb_tm11_dma;
   import tm11_pkg::*;

   localparam int DESKEW  = 8;
   localparam int TIMEOUT = 1000;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        init_in_h = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [17:0] cma_in = '0;
   logic [15:0] brc_in = '0;
   logic        busy, done, nxm;
   logic [17:0] cma_out;
   logic [15:0] brc_out;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b0;
   logic [15:0] xfer_count;

   tm11_dma_if bus ();

   tm11_dma #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) u_dut (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .init_in_h  (init_in_h),
      .start      (start),
      .dir        (dir),
      .cma_in     (cma_in),
      .brc_in     (brc_in),
      .busy       (busy),
      .done       (done),
      .nxm        (nxm),
      .cma_out    (cma_out),
      .brc_out    (brc_out),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .bus        (bus),
      .xfer_count (xfer_count)
   );

   always #5 CLOCK = ~CLOCK;

   assign bus.npr_gnt = bus.npr_req;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- Unibus memory responder ----------------
   logic [15:0] mem [int];
   logic        resp_en = 1'b1;
   int          log_n = 0;
   logic [17:0] log_a [8];
   logic [1:0]  log_c [8];
   logic [15:0] log_d [8];

   initial begin
      int dly = 0;
      bus.ssyn_in_h = 1'b0;
      bus.d_in_h    = '0;
      forever begin
         @(negedge CLOCK);
         if (bus.msyn_out_h && !bus.ssyn_in_h && resp_en) begin
            if (dly == 2) begin
               int key;
               logic [15:0] v;
               key = int'(bus.a_out_h >> 1);
               if (bus.c_out_h == C_DATI) begin
                  v = mem.exists(key) ? mem[key] : 16'h0000;
                  bus.d_in_h = v;
               end else if (bus.c_out_h == C_DATOB) begin
                  v = bus.d_out_h;
                  mem[key] = {(mem.exists(key) ? mem[key][15:8] : 8'h00), v[7:0]};
               end else begin
                  v = bus.d_out_h;
                  mem[key] = v;
               end
               if (log_n < 8) begin
                  log_a[log_n] = bus.a_out_h;
                  log_c[log_n] = bus.c_out_h;
                  log_d[log_n] = v;
               end
               log_n++;
               bus.ssyn_in_h = 1'b1;
               dly = 0;
            end else begin
               dly++;
            end
         end else if (!bus.msyn_out_h) begin
            bus.ssyn_in_h = 1'b0;
            dly = 0;
         end
      end
   end

   // ---------------- tape byte source / sink ----------------
   logic [8:0] src_q [$];
   logic [7:0] sink_q [$];

   initial begin
      logic acc = 1'b0;
      forever begin
         @(negedge CLOCK);
         if (acc && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0][7:0];
            in_last  = src_q[0][8];
         end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
            in_last  = 1'b0;
         end
         acc = in_valid && in_ready;
      end
   end

   initial begin
      int tick = 0;
      forever begin
         @(negedge CLOCK);
         tick++;
         out_ready = (tick % 3) != 0;
         if (out_valid && out_ready) sink_q.push_back(out_data);
      end
   end

   // ---------------- monitors ----------------
   int done_cnt = 0;
   int done_busy_bad = 0;
   int msyn_hi_cnt = 0;
   int dk_cnt = 0;
   int last_deskew = -1;

   initial begin
      logic msyn_prev = 1'b0;
      forever begin
         @(negedge CLOCK);
         if (done) done_cnt++;
         if (done && busy) done_busy_bad++;
         if (bus.msyn_out_h) msyn_hi_cnt++;
         if (bus.npr_req && !bus.msyn_out_h) dk_cnt++;
         if (bus.msyn_out_h && !msyn_prev) last_deskew = dk_cnt;
         if (!bus.npr_req) dk_cnt = 0;
         msyn_prev = bus.msyn_out_h;
      end
   end

   // ---------------- transfer table ----------------
   typedef struct {
      logic            dir;
      logic [17:0]     cma;
      logic [15:0]     brc;
      int              nb;
      logic [3:0][7:0] b;
      int              last_at;
      logic [1:0][15:0] rd;
      int              ncyc;
      logic [1:0][17:0] a;
      logic [1:0][1:0]  c;
      logic [1:0][15:0] d;
      logic [17:0]     ecma;
      logic [15:0]     ebrc;
      int              nout;
      logic [3:0][7:0] o;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];
   int   exp_xfer = 0;

   task automatic pulse_start(input logic d, input logic [17:0] c, input logic [15:0] b);
      @(negedge CLOCK);
      start = 1'b1; dir = d; cma_in = c; brc_in = b;
      @(negedge CLOCK);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 4000) begin
         @(negedge CLOCK);
         n++;
      end
      chk({name, "_wait"}, 64'(n < 4000), 64'd1);
      repeat (2) @(negedge CLOCK);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      string nm;
      v = vecs[i];
      nm = $sformatf("v%0d", i);
      log_n = 0;
      done_cnt = 0;
      done_busy_bad = 0;
      sink_q.delete();
      src_q.delete();
      if (v.dir) begin
         mem[int'((v.cma & 18'h3FFFE) >> 1)]     = v.rd[0];
         mem[int'((v.cma & 18'h3FFFE) >> 1) + 1] = v.rd[1];
      end
      for (int k = 0; k < v.nb; k++) src_q.push_back({(k == v.last_at), v.b[k]});
      pulse_start(v.dir, v.cma, v.brc);
      wait_idle(nm);
      exp_xfer += v.ncyc;
      chk({nm, "_ncyc"}, 64'(log_n), 64'(v.ncyc));
      for (int k = 0; k < v.ncyc && k < 2; k++)
         chk($sformatf("%s_cyc%0d", nm, k), {log_a[k], log_c[k], log_d[k]}, {v.a[k], v.c[k], v.d[k]});
      chk({nm, "_cma"}, 64'(cma_out), 64'(v.ecma));
      chk({nm, "_brc"}, 64'(brc_out), 64'(v.ebrc));
      chk({nm, "_nxm"}, 64'(nxm), 64'd0);
      chk({nm, "_done"}, 64'(done_cnt), 64'd1);
      chk({nm, "_done_busy"}, 64'(done_busy_bad), 64'd0);
      chk({nm, "_src_left"}, 64'(src_q.size()), 64'd0);
      chk({nm, "_bus_idle"}, {bus.npr_req, bus.msyn_out_h, bus.a_out_h, bus.c_out_h, bus.d_out_h}, 64'd0);
      chk({nm, "_nout"}, 64'(sink_q.size()), 64'(v.nout));
      for (int k = 0; k < v.nout && k < sink_q.size(); k++)
         chk($sformatf("%s_out%0d", nm, k), 64'(sink_q[k]), 64'(v.o[k]));
`ifdef TM11_DMA_STATS_EN
      chk({nm, "_xfer"}, 64'(xfer_count), 64'(exp_xfer));
`else
      chk({nm, "_xfer"}, 64'(xfer_count), 64'd0);
`endif
      $display("%s: dir=%0d cma=%06o brc=%06o -> cycles=%0d cma_out=%06o brc_out=%06o outs=%0d",
               nm, v.dir, v.cma, v.brc, log_n, cma_out, brc_out, sink_q.size());
   endtask

   initial begin
      vecs[0] = '{dir:0, cma:18'o001000, brc:16'o177774, nb:4, b:{8'h04,8'h03,8'h02,8'h01}, last_at:-1,
                  rd:'0, ncyc:2, a:{18'o001002,18'o001000}, c:{C_DATO,C_DATO}, d:{16'h0403,16'h0201},
                  ecma:18'o001004, ebrc:16'h0000, nout:0, o:'0};
      vecs[1] = '{dir:0, cma:18'o001000, brc:16'o177775, nb:3, b:{8'h00,8'h03,8'h02,8'h01}, last_at:-1,
                  rd:'0, ncyc:2, a:{18'o001002,18'o001000}, c:{C_DATOB,C_DATO}, d:{16'h0003,16'h0201},
                  ecma:18'o001004, ebrc:16'h0000, nout:0, o:'0};
      vecs[2] = '{dir:1, cma:18'o001000, brc:16'o177777, nb:0, b:'0, last_at:-1,
                  rd:{16'h0000,16'h4241}, ncyc:1, a:{18'o0,18'o001000}, c:{C_DATI,C_DATI}, d:{16'h0,16'h4241},
                  ecma:18'o001002, ebrc:16'h0000, nout:1, o:{8'h0,8'h0,8'h0,8'h41}};
      vecs[3] = '{dir:0, cma:18'o001000, brc:16'o177770, nb:3, b:{8'h00,8'h03,8'h02,8'h01}, last_at:2,
                  rd:'0, ncyc:2, a:{18'o001002,18'o001000}, c:{C_DATOB,C_DATO}, d:{16'h0003,16'h0201},
                  ecma:18'o001004, ebrc:16'o177773, nout:0, o:'0};
      vecs[4] = '{dir:1, cma:18'o001001, brc:16'o177776, nb:0, b:'0, last_at:-1,
                  rd:{16'h0000,16'hBEEF}, ncyc:1, a:{18'o0,18'o001000}, c:{C_DATI,C_DATI}, d:{16'h0,16'hBEEF},
                  ecma:18'o001002, ebrc:16'h0000, nout:2, o:{8'h0,8'h0,8'hBE,8'hEF}};
      vecs[5] = '{dir:1, cma:18'o001000, brc:16'o177775, nb:0, b:'0, last_at:-1,
                  rd:{16'h5678,16'h1234}, ncyc:2, a:{18'o001002,18'o001000}, c:{C_DATI,C_DATI}, d:{16'h5678,16'h1234},
                  ecma:18'o001004, ebrc:16'h0000, nout:3, o:{8'h00,8'h78,8'h12,8'h34}};
      vecs[6] = '{dir:0, cma:18'o777776, brc:16'o177776, nb:2, b:{8'h00,8'h00,8'hBB,8'hAA}, last_at:-1,
                  rd:'0, ncyc:1, a:{18'o0,18'o777776}, c:{C_DATO,C_DATO}, d:{16'h0,16'hBBAA},
                  ecma:18'o000000, ebrc:16'h0000, nout:0, o:'0};
      vecs[7] = '{dir:0, cma:18'o001000, brc:16'o177776, nb:2, b:{8'h00,8'h00,8'h02,8'h01}, last_at:1,
                  rd:'0, ncyc:1, a:{18'o0,18'o001000}, c:{C_DATO,C_DATO}, d:{16'h0,16'h0201},
                  ecma:18'o001002, ebrc:16'h0000, nout:0, o:'0};

      // reset state
      repeat (3) @(negedge CLOCK);
      chk("rst_status", {busy, done, nxm, in_ready, out_valid, out_data}, 64'd0);
      chk("rst_cma_brc", {cma_out, brc_out}, 64'd0);
      chk("rst_bus", {bus.npr_req, bus.msyn_out_h, bus.a_out_h, bus.c_out_h, bus.d_out_h}, 64'd0);
      chk("rst_xfer", 64'(xfer_count), 64'd0);
      $display("reset: busy=%0d done=%0d cma=%06o brc=%06o", busy, done, cma_out, brc_out);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLOCK);

      // init raised while MSYN is waiting for a slave that never answers
      begin
         int n = 0;
         resp_en = 1'b0;
         done_cnt = 0;
         pulse_start(1'b1, 18'o001000, 16'o177777);
         while (!bus.msyn_out_h && n < 200) begin
            @(negedge CLOCK);
            n++;
         end
         chk("init_msyn_seen", 64'(bus.msyn_out_h), 64'd1);
         repeat (3) @(negedge CLOCK);
         init_in_h = 1'b1;
         @(negedge CLOCK);
         init_in_h = 1'b0;
         chk("init_bus_drop", {bus.msyn_out_h, bus.npr_req}, 64'd0);
         chk("init_busy", 64'(busy), 64'd0);
         repeat (20) @(negedge CLOCK);
         chk("init_no_done", 64'(done_cnt), 64'd0);
         chk("init_hold", {nxm, cma_out, brc_out}, {1'b0, 18'o001000, 16'o177777});
         $display("init abort: msyn=%0d req=%0d busy=%0d done_pulses=%0d", bus.msyn_out_h, bus.npr_req, busy, done_cnt);
      end

      // non-existent memory, with a start pulse that must be ignored mid-transfer
      begin
         log_n = 0;
         done_cnt = 0;
         msyn_hi_cnt = 0;
         src_q.delete();
         src_q.push_back({1'b0, 8'h11});
         src_q.push_back({1'b0, 8'h22});
         pulse_start(1'b0, 18'o001000, 16'o177776);
         repeat (5) @(negedge CLOCK);
         pulse_start(1'b1, 18'o001400, 16'o177000);
         wait_idle("nxm");
         chk("nxm_msyn_width", 64'(msyn_hi_cnt), 64'(TIMEOUT));
         chk("nxm_flag", 64'(nxm), 64'd1);
         chk("nxm_bus_drop", {bus.msyn_out_h, bus.npr_req}, 64'd0);
         chk("nxm_cma", 64'(cma_out), 64'(18'o001000));
         chk("nxm_brc", 64'(brc_out), 64'd0);
         chk("nxm_done", 64'(done_cnt), 64'd1);
         chk("nxm_no_slave", 64'(log_n), 64'd0);
         chk("nxm_xfer", 64'(xfer_count), 64'd0);
         $display("nxm: nxm=%0d cma=%06o msyn_clocks=%0d done_pulses=%0d", nxm, cma_out, msyn_hi_cnt, done_cnt);
         resp_en = 1'b1;
      end

      // table of transfers; the first also clears the sticky nxm
      for (int i = 0; i < NV; i++) begin
         run_vec(i);
         if (i == 0) chk("deskew", 64'(last_deskew), 64'(DESKEW + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
